id_decode_unit: RTL and testbench
=================================

ID_DECODE_UNIT -- requirements
Module: id_decode_unit

Interface
REQ-001 Parameter WORD_LEN, default 16, data word width; instruction width is 16 regardless.
REQ-002 Parameter REG_ADDR_LEN, default 4, register-file address width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 hazard_detected_in  in  1  forces a bubble when 1.
REQ-006 instruction  in  16  fields: [15:12] opcode, [11:8] dest/src1, [7:4] src2, [7:0] imm8.
REQ-007 reg1, reg2  in  WORD_LEN  register-file read data for src1, src2.
REQ-008 src1, src2  out  REG_ADDR_LEN  combinational: instruction[11:8], instruction[7:4].
REQ-009 br_taken  out  1  combinational: branch_en AND condition result.
REQ-010 Registered outputs: exe_cmd (4), mem_r_en, mem_w_en, wb_en, is_imm, st_or_bne, comp_en, mul_en, mov_en, jump_en (1 each), branch_comm (2), val1, val2 (WORD_LEN), src2_forw, dest (REG_ADDR_LEN).

Function
REQ-011 Decode table (opcode: exe_cmd, set flags; unlisted flags 0):
- 0 NOP: 0000.
- 1 ADD: 0001, wb_en.
- 2 SUB: 0010, wb_en.
- 3 AND: 0011, wb_en.
- 4 OR: 0100, wb_en.
- 5 XOR: 0101, wb_en.
- 6 ADDI: 0001, wb_en, is_imm.
- 7 MUL: 0110, wb_en, mul_en.
- 8 CMP: 0010, wb_en, comp_en.
- 9 MOV: 0111, wb_en, mov_en.
- A LD: 0001, wb_en, mem_r_en, is_imm.
- B ST: 0001, mem_w_en, is_imm, st_or_bne.
- C BEZ: 0000, branch_en, branch_comm=01.
- D BNE: 0000, branch_en, st_or_bne, branch_comm=10.
- E JMP: 0000, branch_en, jump_en, branch_comm=11.
- F: treated as NOP.
REQ-012 hazard_detected_in=1 SHALL force exe_cmd=0000, all enables/flags 0, branch_comm=00, branch_en=0, br_taken=0.
REQ-013 Condition: comm 00 -> 0; 01 -> reg1==0; 10 -> reg1!=reg2; 11 -> 1.
REQ-014 val2 = is_imm ? sign-extended imm8 (bit 7 replicated to WORD_LEN) : reg2; val1 = reg1.
REQ-015 src2_forw = is_imm ? 0 : instruction[7:4].
REQ-016 dest = comp_en ? 4'd9 : instruction[11:8].
REQ-017 Registered outputs SHALL capture the decoded values of REQ-011..016 on each rising clk edge; latency one cycle.
REQ-018 br_taken, src1, src2 SHALL be purely combinational from current inputs, zero latency.
REQ-019 Under hazard, val1/val2/src2_forw/dest SHALL still be registered from datapath inputs; only control fields are zeroed.
REQ-020 No X propagation: all decode outputs SHALL be defined for every opcode.

Reset
REQ-021 rst=0 SHALL immediately clear every registered output to 0, independent of clk.
REQ-022 While rst=0, registers SHALL hold 0; first capture occurs on the first rising clk after rst returns to 1.
REQ-023 Combinational outputs SHALL be unaffected by rst.

Verification
REQ-024 ADDI, instruction 0x6A85 (imm 0x85) -> after one edge: exe_cmd=0001, wb_en=1, is_imm=1, val2=0xFF85, src2_forw=0, dest=0xA.
REQ-025 BNE 0xD120, reg1=5, reg2=5 -> br_taken=0; reg2=6 -> br_taken=1; st_or_bne=1 registered.
REQ-026 CMP 0x8340 -> registered dest=9, comp_en=1, exe_cmd=0010, val2=reg2.
REQ-027 JMP 0xE000 with hazard_detected_in=1 -> br_taken=0, registered jump_en=0, exe_cmd=0000; hazard=0 -> br_taken=1, jump_en=1.
REQ-028 Assert rst=0 mid-cycle after ST 0xB2F0 captured -> all registered outputs 0 immediately; release -> next edge recaptures mem_w_en=1, val2=0xFFF0.

Source files
------------

// File: rtl/id_decode_unit.sv
// id_decode_unit
//   Instruction decode stage. Splits a 16-bit instruction into its fields,
//   produces execute/memory/writeback control, resolves the branch condition
//   combinationally and registers everything the execute stage needs.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset of all registered outputs
//   hazard_detected_in  1 = insert a bubble (all control zeroed, datapath kept)
//   instruction[15:0]   [15:12] opcode, [11:8] dest/src1, [7:4] src2, [7:0] imm8
//   reg1, reg2          register-file read data for src1 / src2
//   src1, src2          combinational register-file read addresses
//   br_taken            combinational: branch enabled and condition true
//   exe_cmd ... dest    registered decode results (one cycle latency)

module id_decode_unit #(
  parameter int WORD_LEN     = 16,
  parameter int REG_ADDR_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hazard_detected_in,
  input  logic [15:0]             instruction,
  input  logic [WORD_LEN-1:0]     reg1,
  input  logic [WORD_LEN-1:0]     reg2,
  output logic [REG_ADDR_LEN-1:0] src1,
  output logic [REG_ADDR_LEN-1:0] src2,
  output logic                    br_taken,
  output logic [3:0]              exe_cmd,
  output logic                    mem_r_en,
  output logic                    mem_w_en,
  output logic                    wb_en,
  output logic                    is_imm,
  output logic                    st_or_bne,
  output logic                    comp_en,
  output logic                    mul_en,
  output logic                    mov_en,
  output logic                    jump_en,
  output logic [1:0]              branch_comm,
  output logic [WORD_LEN-1:0]     val1,
  output logic [WORD_LEN-1:0]     val2,
  output logic [REG_ADDR_LEN-1:0] src2_forw,
  output logic [REG_ADDR_LEN-1:0] dest
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_MUL  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BEZ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;

  localparam logic [REG_ADDR_LEN-1:0] CMP_DEST = REG_ADDR_LEN'(9);

  function automatic logic signed [WORD_LEN-1:0] sign_ext_imm(input logic [7:0] imm);
    logic signed [7:0] imm_s;
    imm_s = $signed(imm);
    return WORD_LEN'(imm_s);
  endfunction

  logic [3:0] opcode;
  assign opcode = instruction[15:12];

  // Raw decode (before hazard gating)
  logic [3:0] dec_exe;
  logic       dec_mem_r, dec_mem_w, dec_wb, dec_imm, dec_st_bne;
  logic       dec_comp, dec_mul, dec_mov, dec_jump, dec_branch;
  logic [1:0] dec_comm;

  always_comb begin
    dec_exe    = 4'b0000;
    dec_mem_r  = 1'b0;
    dec_mem_w  = 1'b0;
    dec_wb     = 1'b0;
    dec_imm    = 1'b0;
    dec_st_bne = 1'b0;
    dec_comp   = 1'b0;
    dec_mul    = 1'b0;
    dec_mov    = 1'b0;
    dec_jump   = 1'b0;
    dec_branch = 1'b0;
    dec_comm   = 2'b00;
    case (opcode)
      OP_ADD:  begin dec_exe = 4'b0001; dec_wb = 1'b1; end
      OP_SUB:  begin dec_exe = 4'b0010; dec_wb = 1'b1; end
      OP_AND:  begin dec_exe = 4'b0011; dec_wb = 1'b1; end
      OP_OR:   begin dec_exe = 4'b0100; dec_wb = 1'b1; end
      OP_XOR:  begin dec_exe = 4'b0101; dec_wb = 1'b1; end
      OP_ADDI: begin dec_exe = 4'b0001; dec_wb = 1'b1; dec_imm = 1'b1; end
      OP_MUL:  begin dec_exe = 4'b0110; dec_wb = 1'b1; dec_mul = 1'b1; end
      OP_CMP:  begin dec_exe = 4'b0010; dec_wb = 1'b1; dec_comp = 1'b1; end
      OP_MOV:  begin dec_exe = 4'b0111; dec_wb = 1'b1; dec_mov = 1'b1; end
      OP_LD:   begin
        dec_exe = 4'b0001; dec_wb = 1'b1; dec_mem_r = 1'b1; dec_imm = 1'b1;
      end
      OP_ST:   begin
        dec_exe = 4'b0001; dec_mem_w = 1'b1; dec_imm = 1'b1; dec_st_bne = 1'b1;
      end
      OP_BEZ:  begin dec_branch = 1'b1; dec_comm = 2'b01; end
      OP_BNE:  begin dec_branch = 1'b1; dec_st_bne = 1'b1; dec_comm = 2'b10; end
      OP_JMP:  begin dec_branch = 1'b1; dec_jump = 1'b1; dec_comm = 2'b11; end
      OP_NOP:  ;
      default: ;  // opcode F behaves as NOP
    endcase
  end

  // Bubble insertion: only control is zeroed, datapath fields keep their
  // normally decoded values so forwarding/debug still sees the instruction.
  logic [3:0] ctl_exe;
  logic       ctl_mem_r, ctl_mem_w, ctl_wb, ctl_imm, ctl_st_bne;
  logic       ctl_comp, ctl_mul, ctl_mov, ctl_jump, ctl_branch;
  logic [1:0] ctl_comm;

  always_comb begin
    ctl_exe    = dec_exe;
    ctl_mem_r  = dec_mem_r;
    ctl_mem_w  = dec_mem_w;
    ctl_wb     = dec_wb;
    ctl_imm    = dec_imm;
    ctl_st_bne = dec_st_bne;
    ctl_comp   = dec_comp;
    ctl_mul    = dec_mul;
    ctl_mov    = dec_mov;
    ctl_jump   = dec_jump;
    ctl_branch = dec_branch;
    ctl_comm   = dec_comm;
    if (hazard_detected_in) begin
      ctl_exe    = 4'b0000;
      ctl_mem_r  = 1'b0;
      ctl_mem_w  = 1'b0;
      ctl_wb     = 1'b0;
      ctl_imm    = 1'b0;
      ctl_st_bne = 1'b0;
      ctl_comp   = 1'b0;
      ctl_mul    = 1'b0;
      ctl_mov    = 1'b0;
      ctl_jump   = 1'b0;
      ctl_branch = 1'b0;
      ctl_comm   = 2'b00;
    end
  end

  logic cond;
  always_comb begin
    cond = 1'b0;
    case (ctl_comm)
      2'b01:   cond = (reg1 == '0);
      2'b10:   cond = (reg1 != reg2);
      2'b11:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign br_taken = ctl_branch & cond;
  assign src1     = REG_ADDR_LEN'(instruction[11:8]);
  assign src2     = REG_ADDR_LEN'(instruction[7:4]);

  logic [WORD_LEN-1:0]     nxt_val2;
  logic [REG_ADDR_LEN-1:0] nxt_src2_forw;
  logic [REG_ADDR_LEN-1:0] nxt_dest;

  assign nxt_val2      = dec_imm ? sign_ext_imm(instruction[7:0]) : reg2;
  assign nxt_src2_forw = dec_imm ? '0 : REG_ADDR_LEN'(instruction[7:4]);
  assign nxt_dest      = dec_comp ? CMP_DEST : REG_ADDR_LEN'(instruction[11:8]);

  // ID -> EXE stage boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_cmd     <= '0;
      mem_r_en    <= 1'b0;
      mem_w_en    <= 1'b0;
      wb_en       <= 1'b0;
      is_imm      <= 1'b0;
      st_or_bne   <= 1'b0;
      comp_en     <= 1'b0;
      mul_en      <= 1'b0;
      mov_en      <= 1'b0;
      jump_en     <= 1'b0;
      branch_comm <= '0;
      val1        <= '0;
      val2        <= '0;
      src2_forw   <= '0;
      dest        <= '0;
    end else begin
      exe_cmd     <= ctl_exe;
      mem_r_en    <= ctl_mem_r;
      mem_w_en    <= ctl_mem_w;
      wb_en       <= ctl_wb;
      is_imm      <= ctl_imm;
      st_or_bne   <= ctl_st_bne;
      comp_en     <= ctl_comp;
      mul_en      <= ctl_mul;
      mov_en      <= ctl_mov;
      jump_en     <= ctl_jump;
      branch_comm <= ctl_comm;
      val1        <= reg1;
      val2        <= nxt_val2;
      src2_forw   <= nxt_src2_forw;
      dest        <= nxt_dest;
    end
  end

endmodule

// File: tb/tb_id_decode_unit.sv
// tb_id_decode_unit
//   Self-checking bench for id_decode_unit: directed scenarios plus a
//   randomized run compared against a table-driven reference model.

module tb_id_decode_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hazard_detected_in = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic [15:0] reg1 = 16'h0000;
  logic [15:0] reg2 = 16'h0000;
  logic [3:0]  src1, src2;
  logic        br_taken;
  logic [3:0]  exe_cmd;
  logic        mem_r_en, mem_w_en, wb_en, is_imm, st_or_bne;
  logic        comp_en, mul_en, mov_en, jump_en;
  logic [1:0]  branch_comm;
  logic [15:0] val1, val2;
  logic [3:0]  src2_forw, dest;

  int checks = 0;
  int errors = 0;

  id_decode_unit #(.WORD_LEN(16), .REG_ADDR_LEN(4)) dut (
    .clk(clk), .rst(rst), .hazard_detected_in(hazard_detected_in),
    .instruction(instruction), .reg1(reg1), .reg2(reg2),
    .src1(src1), .src2(src2), .br_taken(br_taken),
    .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_en(wb_en), .is_imm(is_imm), .st_or_bne(st_or_bne),
    .comp_en(comp_en), .mul_en(mul_en), .mov_en(mov_en), .jump_en(jump_en),
    .branch_comm(branch_comm), .val1(val1), .val2(val2),
    .src2_forw(src2_forw), .dest(dest)
  );

  always #5 clk = ~clk;

  // Opcode property tables: bit N set means opcode N has the property.
  localparam logic [15:0] WB_OPS   = 16'h07FE;  // 1..A
  localparam logic [15:0] IMM_OPS  = 16'h0C40;  // 6, A, B
  localparam logic [15:0] MEMR_OPS = 16'h0400;  // A
  localparam logic [15:0] MEMW_OPS = 16'h0800;  // B
  localparam logic [15:0] STB_OPS  = 16'h2800;  // B, D
  localparam logic [15:0] CMP_OPS  = 16'h0100;  // 8
  localparam logic [15:0] MUL_OPS  = 16'h0080;  // 7
  localparam logic [15:0] MOV_OPS  = 16'h0200;  // 9
  localparam logic [15:0] JMP_OPS  = 16'h4000;  // E
  localparam logic [15:0] BR_OPS   = 16'h7000;  // C, D, E

  logic [3:0] exe_tab [16];
  logic [1:0] comm_tab [16];

  // Registered outputs packed: exe(4) flags(9) comm(2) val1 val2 src2_forw dest
  function automatic logic [54:0] observed();
    return {exe_cmd, mem_r_en, mem_w_en, wb_en, is_imm, st_or_bne, comp_en,
            mul_en, mov_en, jump_en, branch_comm, val1, val2, src2_forw, dest};
  endfunction

  function automatic logic [54:0] model(input logic [15:0] ins, input logic hz,
                                        input logic [15:0] r1, input logic [15:0] r2,
                                        output logic br);
    int op;
    logic imm, cmp, en;
    logic [1:0] comm;
    logic [15:0] v2;
    logic [3:0] sf, ds;
    op  = int'(ins[15:12]);
    imm = IMM_OPS[op];
    cmp = CMP_OPS[op];
    en  = !hz;
    comm = en ? comm_tab[op] : 2'b00;
    v2 = imm ? 16'($signed(ins[7:0])) : r2;
    sf = imm ? 4'd0 : ins[7:4];
    ds = cmp ? 4'd9 : ins[11:8];
    br = 1'b0;
    if (en && BR_OPS[op]) begin
      if (comm == 2'b01) br = (r1 == 16'd0);
      else if (comm == 2'b10) br = (r1 != r2);
      else if (comm == 2'b11) br = 1'b1;
    end
    return {(en ? exe_tab[op] : 4'd0),
            en & MEMR_OPS[op], en & MEMW_OPS[op], en & WB_OPS[op], en & imm,
            en & STB_OPS[op], en & cmp, en & MUL_OPS[op], en & MOV_OPS[op],
            en & JMP_OPS[op], comm, r1, v2, sf, ds};
  endfunction

  task automatic drive(input logic [15:0] ins, input logic hz,
                       input logic [15:0] r1, input logic [15:0] r2);
    @(negedge clk);
    instruction = ins;
    hazard_detected_in = hz;
    reg1 = r1;
    reg2 = r2;
    #1;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instruction = 16'h1234;
    reg1 = 16'hAAAA;
    reg2 = 16'h5555;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== 55'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", observed());
    end
    checks++;
    if (src1 !== 4'h2 || src2 !== 4'h3) begin
      errors++;
      $display("FAIL reset_comb_src: got %h/%h expected 2/3", src1, src2);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_addi();
    logic [54:0] exp_v;
    logic br;
    drive(16'h6A85, 1'b0, 16'h1234, 16'h5555);
    exp_v = model(16'h6A85, 1'b0, 16'h1234, 16'h5555, br);
    edge_sample();
    checks++;
    if (exe_cmd !== 4'b0001 || wb_en !== 1'b1 || is_imm !== 1'b1 ||
        val2 !== 16'hFF85 || src2_forw !== 4'h0 || dest !== 4'hA) begin
      errors++;
      $display("FAIL addi_fields: exe=%b wb=%b imm=%b val2=%h sf=%h dest=%h expected 0001 1 1 ff85 0 a",
               exe_cmd, wb_en, is_imm, val2, src2_forw, dest);
    end
    checks++;
    if (observed() !== exp_v) begin
      errors++;
      $display("FAIL addi_all: got %h expected %h", observed(), exp_v);
    end
  endtask

  task automatic test_bne();
    drive(16'hD120, 1'b0, 16'd5, 16'd5);
    checks++;
    if (br_taken !== 1'b0) begin
      errors++;
      $display("FAIL bne_equal: br_taken=%b expected 0", br_taken);
    end
    reg2 = 16'd6;
    #1;
    checks++;
    if (br_taken !== 1'b1) begin
      errors++;
      $display("FAIL bne_differ: br_taken=%b expected 1", br_taken);
    end
    checks++;
    if (src1 !== 4'h1 || src2 !== 4'h2) begin
      errors++;
      $display("FAIL bne_src: got %h/%h expected 1/2", src1, src2);
    end
    edge_sample();
    checks++;
    if (st_or_bne !== 1'b1 || branch_comm !== 2'b10 || exe_cmd !== 4'd0) begin
      errors++;
      $display("FAIL bne_reg: st_or_bne=%b comm=%b exe=%b expected 1 10 0000",
               st_or_bne, branch_comm, exe_cmd);
    end
  endtask

  task automatic test_cmp();
    drive(16'h8340, 1'b0, 16'h0101, 16'hBEEF);
    edge_sample();
    checks++;
    if (dest !== 4'd9 || comp_en !== 1'b1 || exe_cmd !== 4'b0010 ||
        val2 !== 16'hBEEF || wb_en !== 1'b1) begin
      errors++;
      $display("FAIL cmp_fields: dest=%h comp=%b exe=%b val2=%h wb=%b expected 9 1 0010 beef 1",
               dest, comp_en, exe_cmd, val2, wb_en);
    end
  endtask

  task automatic test_jmp_hazard();
    drive(16'hE000, 1'b1, 16'h0000, 16'h0000);
    checks++;
    if (br_taken !== 1'b0) begin
      errors++;
      $display("FAIL jmp_hz_br: br_taken=%b expected 0", br_taken);
    end
    edge_sample();
    checks++;
    if (jump_en !== 1'b0 || exe_cmd !== 4'd0 || branch_comm !== 2'b00) begin
      errors++;
      $display("FAIL jmp_hz_reg: jump=%b exe=%b comm=%b expected 0 0000 00",
               jump_en, exe_cmd, branch_comm);
    end
    drive(16'hE000, 1'b0, 16'h0000, 16'h0000);
    checks++;
    if (br_taken !== 1'b1) begin
      errors++;
      $display("FAIL jmp_br: br_taken=%b expected 1", br_taken);
    end
    edge_sample();
    checks++;
    if (jump_en !== 1'b1 || branch_comm !== 2'b11) begin
      errors++;
      $display("FAIL jmp_reg: jump=%b comm=%b expected 1 11", jump_en, branch_comm);
    end
  endtask

  task automatic test_async_reset();
    drive(16'hB2F0, 1'b0, 16'h0042, 16'h7777);
    edge_sample();
    checks++;
    if (mem_w_en !== 1'b1 || val2 !== 16'hFFF0 || val1 !== 16'h0042) begin
      errors++;
      $display("FAIL st_capture: mem_w=%b val2=%h val1=%h expected 1 fff0 0042",
               mem_w_en, val2, val1);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (observed() !== 55'd0) begin
      errors++;
      $display("FAIL async_clear: got %h expected 0", observed());
    end
    checks++;
    if (src1 !== 4'h2 || src2 !== 4'hF) begin
      errors++;
      $display("FAIL reset_comb: src=%h/%h expected 2/f", src1, src2);
    end
    edge_sample();
    checks++;
    if (observed() !== 55'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0", observed());
    end
    @(negedge clk);
    rst = 1'b1;
    edge_sample();
    checks++;
    if (mem_w_en !== 1'b1 || val2 !== 16'hFFF0 || st_or_bne !== 1'b1) begin
      errors++;
      $display("FAIL st_recapture: mem_w=%b val2=%h sb=%b expected 1 fff0 1",
               mem_w_en, val2, st_or_bne);
    end
  endtask

  task automatic test_random();
    logic [54:0] exp_v;
    logic exp_br;
    logic [15:0] ins, r1, r2;
    logic hz;
    for (int i = 0; i < 300; i++) begin
      ins = 16'($urandom);
      hz  = ($urandom_range(0, 3) == 0);
      r1  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      r2  = ($urandom_range(0, 2) == 0) ? r1 : 16'($urandom);
      drive(ins, hz, r1, r2);
      exp_v = model(ins, hz, r1, r2, exp_br);
      checks++;
      if (br_taken !== exp_br || src1 !== ins[11:8] || src2 !== ins[7:4]) begin
        errors++;
        $display("FAIL rand_comb[%0d] ins=%h hz=%b: br=%b src=%h/%h expected %b %h/%h",
                 i, ins, hz, br_taken, src1, src2, exp_br, ins[11:8], ins[7:4]);
      end
      edge_sample();
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL rand_reg[%0d] ins=%h hz=%b: got %h expected %h",
                 i, ins, hz, observed(), exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [54:0] exp_v;
    logic exp_br;
    for (int op = 0; op < 16; op++) begin
      drive({4'(op), 4'h7, 4'h8, 4'h9}, 1'b0, 16'h0000, 16'h1111);
      exp_v = model({4'(op), 4'h7, 4'h8, 4'h9}, 1'b0, 16'h0000, 16'h1111, exp_br);
      checks++;
      if (br_taken !== exp_br) begin
        errors++;
        $display("FAIL b2b_br op=%0d: got %b expected %b", op, br_taken, exp_br);
      end
      edge_sample();
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL b2b_reg op=%0d: got %h expected %h", op, observed(), exp_v);
      end
    end
  endtask

  initial begin
    exe_tab  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h1, 4'h6,
                 4'h2, 4'h7, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    comm_tab = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    test_reset();
    test_addi();
    test_bne();
    test_cmp();
    test_jmp_hazard();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
